ryuki_data_memory: RTL and testbench

// Single-port, word-organised data RAM model for the ryuki RISC-V system testbench.

---
 rtl/ryuki_data_memory_pkg.sv | 10 +
 rtl/ryuki_dmem_array.sv | 28 ++
 rtl/ryuki_data_memory.sv | 55 +++++
 tb/tb_ryuki_data_memory.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ryuki_data_memory_pkg.sv
// ryuki_data_memory_pkg: shared defaults and response record for the ryuki data memory
package ryuki_data_memory_pkg;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_WORDS  = 1024;
  typedef struct packed {
    logic valid;
    logic err;
  } dmem_rsp_t;
endpackage

// File: rtl/ryuki_dmem_array.sv
// ryuki_dmem_array: byte-lane write-enabled RAM with registered read port
module ryuki_dmem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 1024,
  parameter int IDX_WIDTH  = $clog2(NUM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we,
  input  logic                    re,
  input  logic                    clr,
  input  logic [IDX_WIDTH-1:0]    idx,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < BE_WIDTH; k++)
      if (we && be[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
  end
  // Read data register doubles as the response data: cleared for writes/errors, held when idle
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/ryuki_data_memory.sv
// ryuki_data_memory: zero-wait-state data RAM on the req/gnt/rvalid port with range checking
module ryuki_data_memory
  import ryuki_data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WORDS  = DEF_NUM_WORDS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);
  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = $clog2(NUM_WORDS);
  localparam int WORD_OFF  = $clog2(BE_WIDTH);
  localparam int WW        = ADDR_WIDTH - WORD_OFF;
  localparam logic [WW-1:0] LIMIT = WW'(NUM_WORDS);
  logic [WW-1:0] word;
  logic          in_range;
  logic          unused_lo;
  dmem_rsp_t     rsp;
  assign word       = data_addr_i[ADDR_WIDTH-1:WORD_OFF];
  assign unused_lo  = ^data_addr_i[WORD_OFF-1:0];
  assign in_range   = word < LIMIT;
  assign data_gnt_o = data_req_i & rst_ni;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) rsp <= '0;
    else rsp <= '{valid: data_req_i, err: data_req_i & ~in_range};
  end
  assign data_rvalid_o = rsp.valid;
  assign data_err_o    = rsp.err;
  ryuki_dmem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_WORDS (NUM_WORDS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_array (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (data_gnt_o & data_we_i & in_range),
    .re    (data_gnt_o & ~data_we_i & in_range),
    .clr   (data_gnt_o & (data_we_i | ~in_range)),
    .idx   (word[IDX_WIDTH-1:0]),
    .be    (data_be_i),
    .wdata (data_wdata_i),
    .rdata (data_rdata_o)
  );
endmodule

// File: tb/tb_ryuki_data_memory.sv
// tb_ryuki_data_memory: directed vector table plus reset corner sequences
module tb_ryuki_data_memory;
  logic        clk_i = 0;
  logic        rst_ni = 0;
  logic        data_req_i = 0;
  logic [31:0] data_addr_i = '0;
  logic        data_we_i = 0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  int n_cmp = 0;
  int n_bad = 0;

  ryuki_data_memory dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_req_i(data_req_i), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .data_err_o(data_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata);
    @(negedge clk_i);
    data_req_i = req; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wdata;
  endtask

  task automatic check_rsp(input string name, input logic rv, input logic [31:0] rd, input logic er);
    check({name, ".rvalid"}, 32'(data_rvalid_o), 32'(rv));
    check({name, ".rdata"}, data_rdata_o, rd);
    check({name, ".err"}, 32'(data_err_o), 32'(er));
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1, 1, 32'h40, 4'hF, 32'hDEADBEEF, 1, 1, 32'h0, 0},
      '{1, 0, 32'h40, 4'h0, 32'h0,        1, 1, 32'hDEADBEEF, 0},
      '{1, 1, 32'h40, 4'h5, 32'h11223344, 1, 1, 32'h0, 0},
      '{1, 0, 32'h40, 4'h0, 32'h0,        1, 1, 32'hDE22BE44, 0},
      '{1, 1, 32'h44, 4'hF, 32'hCAFEF00D, 1, 1, 32'h0, 0},
      '{1, 1, 32'h48, 4'hF, 32'h01234567, 1, 1, 32'h0, 0},
      '{1, 0, 32'h40, 4'h0, 32'h0,        1, 1, 32'hDE22BE44, 0},
      '{1, 0, 32'h44, 4'h0, 32'h0,        1, 1, 32'hCAFEF00D, 0},
      '{1, 0, 32'h48, 4'h0, 32'h0,        1, 1, 32'h01234567, 0},
      '{0, 0, 32'h40, 4'h0, 32'h0,        0, 0, 32'h01234567, 0},
      '{1, 1, 32'h0,  4'hF, 32'hA5A5A5A5, 1, 1, 32'h0, 0},
      '{1, 1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1, 1, 32'h0, 1},
      '{1, 0, 32'h1000, 4'h0, 32'h0,      1, 1, 32'h0, 1},
      '{1, 0, 32'h0,  4'h0, 32'h0,        1, 1, 32'hA5A5A5A5, 0},
      '{1, 0, 32'h43, 4'h0, 32'h0,        1, 1, 32'hDE22BE44, 0},
      '{1, 1, 32'h44, 4'h0, 32'h55555555, 1, 1, 32'h0, 0},
      '{1, 0, 32'h44, 4'h0, 32'h0,        1, 1, 32'hCAFEF00D, 0},
      '{1, 1, 32'hFFC, 4'hF, 32'h13579BDF, 1, 1, 32'h0, 0},
      '{1, 0, 32'hFFC, 4'h0, 32'h0,       1, 1, 32'h13579BDF, 0},
      '{1, 0, 32'h20000000, 4'h0, 32'h0,  1, 1, 32'h0, 1},
      '{0, 1, 32'h48, 4'hF, 32'h0,        0, 0, 32'h0, 0}
    };
    // Reset held with a write request pending: nothing granted, no response
    rst_ni = 0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 32'h40, 4'hF, 32'h99999999);
      #1 check($sformatf("rst%0d.gnt", i), 32'(data_gnt_o), 32'h0);
      @(posedge clk_i); #1;
      check_rsp($sformatf("rst%0d", i), 0, 32'h0, 0);
    end
    drive(0, 0, 32'h0, 4'h0, 32'h0);
    rst_ni = 1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      #1 check($sformatf("v%0d.gnt", i), 32'(data_gnt_o), 32'(vecs[i].gnt));
      @(posedge clk_i); #1;
      check_rsp($sformatf("v%0d", i), vecs[i].rvalid, vecs[i].rdata, vecs[i].err);
    end
    // Reset lands the cycle after a read grant: the response already presented is dropped afterwards
    drive(1, 0, 32'h44, 4'h0, 32'h0);
    @(posedge clk_i); #1;
    check_rsp("mid.grant", 1, 32'hCAFEF00D, 0);
    drive(1, 1, 32'h40, 4'hF, 32'h77777777);
    rst_ni = 0;
    #1 check("mid.gnt", 32'(data_gnt_o), 32'h0);
    @(posedge clk_i); #1;
    check_rsp("mid.rst", 0, 32'h0, 0);
    drive(0, 0, 32'h0, 4'h0, 32'h0);
    rst_ni = 1;
    @(posedge clk_i); #1;
    check_rsp("mid.idle", 0, 32'h0, 0);
    // Contents survive reset and the write attempted during reset never landed
    drive(1, 0, 32'h40, 4'h0, 32'h0);
    @(posedge clk_i); #1;
    check_rsp("keep", 1, 32'hDE22BE44, 0);
    drive(1, 0, 32'h48, 4'h0, 32'h0);
    @(posedge clk_i); #1;
    check_rsp("keep48", 1, 32'h01234567, 0);
    drive(0, 0, 32'h0, 4'h0, 32'h0);
    @(posedge clk_i); #1;
    check_rsp("end.idle", 0, 32'h01234567, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
